frame_sequencer: RTL

Sequences one bitmap frame into the pixel-processing `top` datapath.
- Accepts a valid/ready pixel stream from the source (BMP loader or DMA).
- Drives the datapath's en, hsync, vsync and data inputs with registered timing.
- After the last pixel, runs zero-data flush cycles so downstream stages (labeling merge stacks, data table) drain.
- Then pulses frame_done.

---
 rtl/frame_seq_pkg.sv | 27 ++
 rtl/frame_seq_if.sv | 13 +
 rtl/frame_seq_cnt.sv | 55 +++++
 rtl/frame_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/frame_seq_pkg.sv
// rtl/frame_seq_pkg.sv - shared types and defaults for frame_sequencer
// Contents: default widths, pixel width, FSM state encoding, dimension/flush typedefs.
// PIXEL_SIZE normally comes from global.vh; a 24-bit {B2,B1,B0} default is used when absent.
`ifndef PIXEL_SIZE
`define PIXEL_SIZE 24
`endif

package frame_seq_pkg;

    localparam int DIM_W_DEF   = 16;
    localparam int FLUSH_W_DEF = 16;
    localparam int HBLANK_DEF  = 4;
    localparam int PIX_W       = `PIXEL_SIZE;

    typedef logic [DIM_W_DEF-1:0]   dim_t;
    typedef logic [FLUSH_W_DEF-1:0] flush_t;

    // S_BLANK is only reachable when FRAME_SEQ_HBLANK_EN is defined.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACTIVE = 3'd1,
        S_BLANK  = 3'd2,
        S_FLUSH  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/frame_seq_if.sv
// rtl/frame_seq_if.sv - valid/ready pixel stream from the source into the sequencer
// Signals: s_valid (source has a pixel), s_ready (sequencer accepts), s_data (pixel {B2,B1,B0}).
// Modports: master = pixel source, slave = frame_sequencer.
interface frame_seq_if;

    logic                           s_valid;
    logic                           s_ready;
    logic [frame_seq_pkg::PIX_W-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/frame_seq_cnt.sv
// rtl/frame_seq_cnt.sv - x/y raster counter with row wrap and last-column/last-row flags
// Ports: clk, rst_n (async active-low), clear_i (zero both counters), advance_i (one pixel
//        accepted), col_max_i/row_max_i (latched width-1/height-1), col_o/row_o (position of
//        the next pixel), last_col_o/last_row_o (position sits on the final column/row).
module frame_seq_cnt
#(
    parameter int DIM_W = frame_seq_pkg::DIM_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             advance_i,
    input  logic [DIM_W-1:0] col_max_i,
    input  logic [DIM_W-1:0] row_max_i,
    output logic [DIM_W-1:0] col_o,
    output logic [DIM_W-1:0] row_o,
    output logic             last_col_o,
    output logic             last_row_o
);

    logic [DIM_W-1:0] col_q, col_d;
    logic [DIM_W-1:0] row_q, row_d;

    assign last_col_o = (col_q == col_max_i);
    assign last_row_o = (row_q == row_max_i);
    assign col_o      = col_q;
    assign row_o      = row_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
        end else if (advance_i) begin
            if (last_col_o) begin
                col_d = '0;
                row_d = last_row_o ? '0 : row_q + DIM_W'(1);
            end else begin
                col_d = col_q + DIM_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - sequences one bitmap frame into the pixel datapath, then flushes it
// Ports: clk, reset_n (async active-low), start/abort controls, width/height/flush_len (latched
//        on an accepted start), src (pixel stream slave), en/hsync/vsync/pix_data/x/y (registered
//        datapath drive), busy (not IDLE), frame_done (one-cycle pulse at frame end).
// Optional macro FRAME_SEQ_HBLANK_EN: inserts HBLANK idle cycles between rows.
module frame_sequencer
    import frame_seq_pkg::*;
#(
    parameter int DIM_W   = DIM_W_DEF,
    parameter int FLUSH_W = FLUSH_W_DEF
`ifdef FRAME_SEQ_HBLANK_EN
    ,
    parameter int HBLANK  = HBLANK_DEF
`endif
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [DIM_W-1:0]   width,
    input  logic [DIM_W-1:0]   height,
    input  logic [FLUSH_W-1:0] flush_len,
    frame_seq_if.slave         src,
    output logic               en,
    output logic               hsync,
    output logic               vsync,
    output logic [PIX_W-1:0]   pix_data,
    output logic [DIM_W-1:0]   x,
    output logic [DIM_W-1:0]   y,
    output logic               busy,
    output logic               frame_done
);

    state_t               state_q, state_d;
    logic [DIM_W-1:0]     w_max_q, w_max_d;
    logic [DIM_W-1:0]     h_max_q, h_max_d;
    logic [FLUSH_W-1:0]   flen_q, flen_d;
    logic [FLUSH_W-1:0]   cnt_q, cnt_d;
    logic                 en_q, en_d;
    logic                 hsync_q, hsync_d;
    logic                 vsync_q, vsync_d;
    logic [PIX_W-1:0]     pix_q, pix_d;
    logic [DIM_W-1:0]     x_q, x_d;
    logic [DIM_W-1:0]     y_q, y_d;
    logic                 done_q, done_d;

    logic                 s_ready_c;
    logic                 beat;
    logic                 cnt_clear;
    logic [DIM_W-1:0]     col, row;
    logic                 last_col, last_row, last_pix;

    frame_seq_cnt #(.DIM_W(DIM_W)) u_cnt (
        .clk        (clk),
        .rst_n      (reset_n),
        .clear_i    (cnt_clear),
        .advance_i  (beat),
        .col_max_i  (w_max_q),
        .row_max_i  (h_max_q),
        .col_o      (col),
        .row_o      (row),
        .last_col_o (last_col),
        .last_row_o (last_row)
    );

    assign last_pix    = last_col & last_row;
    assign src.s_ready = s_ready_c;

    always_comb begin
        state_d   = state_q;
        w_max_d   = w_max_q;
        h_max_d   = h_max_q;
        flen_d    = flen_q;
        cnt_d     = cnt_q;
        en_d      = 1'b0;
        hsync_d   = 1'b0;
        vsync_d   = 1'b0;
        pix_d     = pix_q;
        x_d       = x_q;
        y_d       = y_q;
        done_d    = 1'b0;
        s_ready_c = 1'b0;
        beat      = 1'b0;
        cnt_clear = 1'b0;

        // Abort outranks everything, including a final beat; s_ready is held low so the
        // source never sees a handshake for a pixel that is being dropped.
        if (abort) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            cnt_clear = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        // Store width-1/height-1 so the raster compare needs no subtractor.
                        w_max_d   = width - DIM_W'(1);
                        h_max_d   = height - DIM_W'(1);
                        flen_d    = flush_len;
                        cnt_clear = 1'b1;
                        state_d   = (width == '0 || height == '0) ? S_DONE : S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    s_ready_c = 1'b1;
                    beat      = src.s_valid;
                    if (beat) begin
                        en_d    = 1'b1;
                        pix_d   = src.s_data;
                        x_d     = col;
                        y_d     = row;
                        hsync_d = (col == '0);
                        vsync_d = (col == '0) && (row == '0);
                        if (last_pix) begin
                            if (flen_q == '0) begin
                                state_d = S_DONE;
                            end else begin
                                state_d = S_FLUSH;
                                cnt_d   = flen_q;
                            end
                        end
`ifdef FRAME_SEQ_HBLANK_EN
                        else if (last_col && (HBLANK != 0)) begin
                            state_d = S_BLANK;
                            cnt_d   = FLUSH_W'(HBLANK);
                        end
`endif
                    end
                end
                S_BLANK: begin
                    cnt_d = cnt_q - FLUSH_W'(1);
                    if (cnt_q == FLUSH_W'(1)) begin
                        state_d = S_ACTIVE;
                    end
                end
                S_FLUSH: begin
                    en_d  = 1'b1;
                    pix_d = '0;
                    cnt_d = cnt_q - FLUSH_W'(1);
                    if (cnt_q == FLUSH_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            w_max_q <= '0;
            h_max_q <= '0;
            flen_q  <= '0;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            pix_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_max_q <= w_max_d;
            h_max_q <= h_max_d;
            flen_q  <= flen_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            pix_q   <= pix_d;
            x_q     <= x_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

    // frame_done is registered out of DONE, so it lands in the first IDLE cycle and
    // busy falls in that same cycle.
    assign en         = en_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign pix_data   = pix_q;
    assign x          = x_q;
    assign y          = y_q;
    assign frame_done = done_q;
    assign busy       = (state_q != S_IDLE);

endmodule
